// File: rtl/pwm_audio_sequencer_pkg.sv
// Shared types and constants for the PWM audio sequencer.
// Holds the mixer FSM encoding, datapath widths and a channel mask helper.
package pwm_audio_sequencer_pkg;

    localparam int NUM_CH   = 4;
    localparam int LEVEL_W  = 4;
    localparam int ACC_W    = 6;
    localparam int SCALED_W = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        SCALE     = 2'd2,
        WAIT_SYNC = 2'd3
    } seq_state_t;

    typedef logic [NUM_CH-1:0][LEVEL_W-1:0] levels_t;

    // Zero the level of every channel whose mix enable is low.
    function automatic levels_t mask_levels(
        input logic [NUM_CH*LEVEL_W-1:0] lv,
        input logic [NUM_CH-1:0]         en
    );
        levels_t m;
        m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m[c] = lv[c*LEVEL_W +: LEVEL_W] & {LEVEL_W{en[c]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_audio_sequencer_if.sv
// Bundle between the APU/PWM side and the audio sequencer.
// master: drives channel levels, volume, enable, period_end; slave: the sequencer.
interface pwm_audio_sequencer_if #(
    parameter int WIDTH = 8
);
    import pwm_audio_sequencer_pkg::*;

    logic                      enable;
    logic [NUM_CH*LEVEL_W-1:0] ch_level;
    logic [NUM_CH-1:0]         ch_enable;
    logic [2:0]                master_vol;
    logic                      pwm_period_end;
    logic [WIDTH-1:0]          duty_out;
    logic                      duty_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output enable,
        output ch_level,
        output ch_enable,
        output master_vol,
        output pwm_period_end,
        input  duty_out,
        input  duty_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  enable,
        input  ch_level,
        input  ch_enable,
        input  master_vol,
        input  pwm_period_end,
        output duty_out,
        output duty_valid,
        output busy,
        output overrun
    );

endinterface

// File: rtl/pwm_audio_sequencer_sample_tick_gen.sv
// Sample-rate divider: tick is high in the last cycle of each SAMPLE_DIV period.
// Ports: clk, reset_n (sync, active low), enable (low holds count at 0), tick.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/pwm_audio_sequencer.sv
// Mixes four channel levels per sample tick, scales by master volume and
// commits the duty to the PWM stage only at a PWM period boundary.
// Ports: clk, reset_n (sync, active low), bus (slave side of the sequencer if).
module pwm_audio_sequencer
    import pwm_audio_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_DIV = 256
) (
    input logic                  clk,
    input logic                  reset_n,
    pwm_audio_sequencer_if.slave bus
);

    logic                tick;
    seq_state_t          state;
    seq_state_t          state_nx;
    levels_t             lvl;
    logic [2:0]          vol;
    logic [ACC_W-1:0]    acc;
    logic [1:0]          idx;
    logic [SCALED_W-1:0] scaled;
    logic [WIDTH-1:0]    mapped;
    logic [WIDTH-1:0]    pend;
    logic [WIDTH-1:0]    duty;
    logic                dv;
    logic                bsy;
    logic                ovr;
    logic                clr;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (bus.enable),
        .tick   (tick)
    );

    // Disabling the sequencer behaves like a reset of the mixing path.
    assign clr = !reset_n || !bus.enable;

    // Gain is vol+1, so the 6-bit sum times at most 8 fits in 9 bits.
    assign scaled = SCALED_W'(acc) * SCALED_W'({1'b0, vol} + 4'd1);

    // Align the 9-bit mix to the PWM duty width.
    if (WIDTH <= SCALED_W) begin : g_shr
        assign mapped = scaled[SCALED_W-1 -: WIDTH];
    end else begin : g_shl
        assign mapped = {scaled, {(WIDTH-SCALED_W){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (tick) state_nx = ACCUM;
            ACCUM:     if (idx == 2'd3) state_nx = SCALE;
            SCALE:     state_nx = WAIT_SYNC;
            WAIT_SYNC: if (bus.pwm_period_end) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            lvl  <= '0;
            vol  <= '0;
            acc  <= '0;
            idx  <= '0;
            pend <= '0;
            duty <= '0;
            dv   <= 1'b0;
            bsy  <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            dv  <= 1'b0;
            // A tick outside IDLE is dropped; the sample in flight carries on.
            ovr <= tick && (state != IDLE);
            bsy <= (state_nx != IDLE);
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        lvl <= mask_levels(bus.ch_level, bus.ch_enable);
                        vol <= bus.master_vol;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(lvl[idx]);
                    idx <= idx + 2'd1;
                end
                SCALE: begin
                    pend <= mapped;
                end
                WAIT_SYNC: begin
                    if (bus.pwm_period_end) begin
                        duty <= pend;
                        dv   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.duty_out   = duty;
    assign bus.duty_valid = dv;
    assign bus.busy       = bsy;
    assign bus.overrun    = ovr;

endmodule

// File: doc/pwm_audio_sequencer.md
Name: pwm_audio_sequencer

Overview:
Sample-rate scheduler and mixer that drives the duty input of the audio PWM output stage. On each sample tick it snapshots the four sound-channel DAC levels and sums them one channel per cycle. It scales the sum by the master volume and commits the result to the PWM duty only at a PWM period boundary, so the output never changes mid-period. It sits between the APU channel generators and the pwm instance.

Parameters:
WIDTH, 8, duty width; must match the WIDTH of the attached pwm instance; legal range 4..12
SAMPLE_DIV, 256, clk cycles per sample tick; legal range is 8 or more

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
enable  input  1  sequencer enable; when low the counter is held and the output is silenced
ch_level  input  16  four 4-bit channel DAC levels; ch0 is in [3:0], ch3 is in [15:12]
ch_enable  input  4  per-channel mix enable
master_vol  input  3  master volume 0..7; the applied gain is master_vol+1
pwm_period_end  input  1  one-cycle pulse from the PWM stage when its counter wraps
duty_out  output  WIDTH  registered duty value; connects to pwm digital_in
duty_valid  output  1  one-cycle pulse on the cycle duty_out takes a new value
busy  output  1  high whenever the FSM is not in IDLE
overrun  output  1  one-cycle pulse when a sample tick is dropped

Behaviour:
- Reset (reset_n low at a clk edge): div counter = 0, FSM = IDLE, all internal registers cleared. Outputs: duty_out = 0, duty_valid = 0, busy = 0, overrun = 0.
- Reset mid-operation aborts any pending result. No commit follows the reset.
- Divider: while enable = 1, the counter counts 0..SAMPLE_DIV-1 and wraps. A tick occurs in the cycle where counter == SAMPLE_DIV-1.
- IDLE:
  - On a tick edge, snapshot ch_level & ch_enable (masked per channel) and master_vol.
  - Clear the accumulator, set idx = 0, go to ACCUM.
- ACCUM: add the masked level of channel idx to a 6-bit accumulator, one channel per edge. Exactly 4 edges; after idx = 3, go to SCALE.
- SCALE (1 edge):
  - scaled = acc * (vol+1), 9 bits, maximum 480.
  - Width mapping: if WIDTH <= 9, result = scaled >> (9-WIDTH); otherwise result = scaled << (WIDTH-9).
  - Store result in a pending register, go to WAIT_SYNC.
- WAIT_SYNC: on the first edge where pwm_period_end = 1, load duty_out from the pending register, pulse duty_valid for 1 cycle, return to IDLE.
- Latency: snapshot at edge E; ACCUM occupies E+1..E+4; SCALE at E+5. Earliest commit is E+6, taken if pwm_period_end is high in the cycle before E+6.
- pwm_period_end is ignored in IDLE, ACCUM and SCALE.
- Tick while FSM != IDLE: the tick is dropped, overrun pulses for 1 cycle, and the in-flight sample continues unaffected.
- Tick and commit on the same edge: the tick is dropped with overrun, because the FSM is not in IDLE at that edge.
- enable deasserted: at the next edge the counter = 0, FSM = IDLE, duty_out = 0, duty_valid = 0, and the pending result is discarded.
- enable reasserted: the first tick occurs SAMPLE_DIV cycles later.
- Input changes after the snapshot have no effect on the sample in flight.
- All outputs are registered. No combinational path exists from inputs to outputs.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ACCUM, SCALE, WAIT_SYNC; 2 bits);
  - constants NUM_CH = 4, LEVEL_W = 4, ACC_W = 6, SCALED_W = 9.
- The divider is a natural sub-module, sample_tick_gen: parameter SAMPLE_DIV, inputs clk, reset_n, enable, output tick.
- Mixing FSM and datapath stay in the top module.

Test Plan:
- WIDTH=8, SAMPLE_DIV=16, all ch_level=15, ch_enable=4'hF, master_vol=7, pwm_period_end pulsed every 4 cycles -> duty_out=240 with a single duty_valid pulse, no earlier than 6 edges after the tick.
- Levels ch0..ch3 = 1,2,3,4, ch_enable=4'b1010, master_vol=0 -> acc=6, scaled=6, duty_out=3. With ch_enable=4'hF and master_vol=3 -> scaled=40, duty_out=20.
- pwm_period_end held low for 40 cycles with SAMPLE_DIV=16 -> busy stays high, overrun pulses at each dropped tick, pending value commits on the first later pwm_period_end, duty_out unchanged until then.
- Change ch_level to 0 two cycles after the snapshot -> committed duty still reflects the snapshotted levels.
- Assert reset_n=0 for 1 cycle while in WAIT_SYNC -> all outputs 0 on the next edge, no duty_valid pulse when pwm_period_end later arrives.
- enable 1->0 while in ACCUM -> next edge duty_out=0, busy=0; re-enable -> first tick exactly SAMPLE_DIV cycles later.
